// File: rtl/pulse_pkg.sv
// Shared definitions for the CPMG pulse sequencer.
// Holds the default field widths, the sync high time, the minimum legal
// period and the FSM state encodings used by cpmg_sequencer.
package pulse_pkg;

    localparam int DEF_PER_W    = 24;
    localparam int DEF_WID_W    = 16;
    localparam int DEF_NBL_W    = 8;
    localparam int DEF_SYNC_LEN = 8;
    localparam int MIN_PER      = 2;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_P1   = 3'd1;
    localparam logic [2:0] S_DEL  = 3'd2;
    localparam logic [2:0] S_P2   = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;
    localparam logic [2:0] S_TAIL = 3'd5;
    localparam logic [2:0] S_WAIT = 3'd6;

    // States during which the receiver is blanked (when blocking is enabled).
    function automatic logic seq_busy(input logic [2:0] s);
        return (s == S_P1) || (s == S_DEL) || (s == S_P2) ||
               (s == S_GAP) || (s == S_TAIL);
    endfunction

endpackage

// File: rtl/cpmg_sequencer_if.sv
// Parameter/strobe bus from pulse_control into the sequencer, plus the
// sequencer's pin-level outputs.
//   master : pulse_control side (drives *_in and rxd, observes outputs)
//   slave  : sequencer side
interface cpmg_sequencer_if #(
    parameter int PER_W = pulse_pkg::DEF_PER_W,
    parameter int WID_W = pulse_pkg::DEF_WID_W,
    parameter int NBL_W = pulse_pkg::DEF_NBL_W
);
    logic [PER_W-1:0] per_in;
    logic [WID_W-1:0] p1wid_in;
    logic [WID_W-1:0] del_in;
    logic [WID_W-1:0] p2wid_in;
    logic             cp_in;
    logic [NBL_W-1:0] nbl_in;
    logic             bl_in;
    logic             rxd;
    logic             sync_on;
    logic             pulse_on;
    logic             inhib;
    logic             upd_ack;
    logic             running;

    modport master (
        output per_in, p1wid_in, del_in, p2wid_in, cp_in, nbl_in, bl_in, rxd,
        input  sync_on, pulse_on, inhib, upd_ack, running
    );

    modport slave (
        input  per_in, p1wid_in, del_in, p2wid_in, cp_in, nbl_in, bl_in, rxd,
        output sync_on, pulse_on, inhib, upd_ack, running
    );
endinterface

// File: rtl/seq_param_shadow.sv
// Double-buffered parameter set.
//   in_set   : raw parameter inputs, captured into the shadow on rxd
//   boundary : high on the cycle where a new set may take effect
//   apply    : combinational, a new set becomes active after this cycle
//   nxt_set  : the set that becomes active when apply is high (rxd bypasses
//              the shadow so same-cycle inputs win)
//   act_set  : set in force for the current period
//   upd_ack  : one-cycle pulse in the first cycle the new set is active
module seq_param_shadow #(
    parameter int SET_W = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [SET_W-1:0] in_set,
    input  logic             rxd,
    input  logic             boundary,
    output logic             apply,
    output logic [SET_W-1:0] nxt_set,
    output logic [SET_W-1:0] act_set,
    output logic             upd_ack
);
    logic [SET_W-1:0] shadow;
    logic             pending;

    assign apply   = boundary & (pending | rxd);
    assign nxt_set = rxd ? in_set : shadow;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shadow  <= '0;
            pending <= 1'b0;
            act_set <= '0;
            upd_ack <= 1'b0;
        end else begin
            if (rxd)
                shadow <= in_set;
            pending <= apply ? 1'b0 : (pending | rxd);
            if (apply)
                act_set <= nxt_set;
            upd_ack <= apply;
        end
    end
endmodule

// File: rtl/cpmg_sequencer.sv
// Cycle-accurate CPMG period scheduler.
//   clk, resetn : PLL clock, asynchronous active-low reset
//   bus         : parameter inputs + rxd strobe in, sync_on/pulse_on/inhib/
//                 upd_ack/running out (all outputs registered)
// One period: P1, DEL, then P2 pulses separated by 2*del GAPs, TAIL (del),
// WAIT until the period wraps. The wrap always wins over an unfinished
// sequence.
module cpmg_sequencer
    import pulse_pkg::*;
#(
    parameter int PER_W    = DEF_PER_W,
    parameter int WID_W    = DEF_WID_W,
    parameter int NBL_W    = DEF_NBL_W,
    parameter int SYNC_LEN = DEF_SYNC_LEN
) (
    input  logic           clk,
    input  logic           resetn,
    cpmg_sequencer_if.slave bus
);
    typedef struct packed {
        logic [PER_W-1:0] per;
        logic [WID_W-1:0] p1wid;
        logic [WID_W-1:0] del;
        logic [WID_W-1:0] p2wid;
        logic             cp;
        logic [NBL_W-1:0] nbl;
        logic             bl;
    } params_t;

    localparam int               SET_W  = $bits(params_t);
    localparam logic [PER_W-1:0] SYNC_L = PER_W'(SYNC_LEN);
    localparam logic [PER_W-1:0] PMIN   = PER_W'(MIN_PER);

    params_t          in_p, act, nxt, eff;
    logic [SET_W-1:0] act_v, nxt_v;
    logic             apply, boundary, wrap;

    logic [2:0]       state, state_n, c;
    logic [PER_W-1:0] pcnt, pcnt_n, per_last, per_e, sync_lim;
    logic [WID_W:0]   seg, seg_n;
    logic [NBL_W-1:0] ecnt, ecnt_n, e, n_tot;
    logic             running, running_n, adv;
    logic             sync_q, pulse_q, inhib_q;

    assign in_p = '{per: bus.per_in, p1wid: bus.p1wid_in, del: bus.del_in,
                    p2wid: bus.p2wid_in, cp: bus.cp_in, nbl: bus.nbl_in,
                    bl: bus.bl_in};

    seq_param_shadow #(.SET_W(SET_W)) u_shadow (
        .clk      (clk),
        .resetn   (resetn),
        .in_set   (in_p),
        .rxd      (bus.rxd),
        .boundary (boundary),
        .apply    (apply),
        .nxt_set  (nxt_v),
        .act_set  (act_v),
        .upd_ack  (bus.upd_ack)
    );

    assign act = params_t'(act_v);
    assign nxt = params_t'(nxt_v);
    // Set governing the cycle being computed (new set on an apply cycle).
    assign eff = apply ? nxt : act;

    assign per_last = (act.per < PMIN) ? (PMIN - PER_W'(1)) : (act.per - PER_W'(1));
    assign wrap     = (state != S_IDLE) && (pcnt == per_last);
    assign boundary = (state == S_IDLE) || wrap;

    assign per_e    = (eff.per < PMIN) ? PMIN : eff.per;
    assign sync_lim = (per_e < SYNC_L) ? per_e : SYNC_L;
    assign n_tot    = (eff.cp && eff.nbl != '0) ? eff.nbl : NBL_W'(1);

    // Segment that follows s. With del=0 and p2wid=0 everything after P1 is
    // empty, so jump straight to WAIT instead of looping through GAP/P2.
    function automatic logic [2:0] nxt_seg(input logic [2:0] s,
                                           input logic [NBL_W-1:0] en,
                                           input params_t p);
        case (s)
            S_P1:    nxt_seg = (p.del == '0 && p.p2wid == '0) ? S_WAIT : S_DEL;
            S_DEL:   nxt_seg = S_P2;
            S_P2:    nxt_seg = (en != '0) ? S_GAP : S_TAIL;
            S_GAP:   nxt_seg = S_P2;
            default: nxt_seg = S_WAIT;
        endcase
    endfunction

    function automatic logic [WID_W:0] seg_len(input logic [2:0] s, input params_t p);
        case (s)
            S_P1:         seg_len = {1'b0, p.p1wid};
            S_DEL, S_TAIL: seg_len = {1'b0, p.del};
            S_P2:         seg_len = {1'b0, p.p2wid};
            S_GAP:        seg_len = {p.del, 1'b0};
            default:      seg_len = '1;
        endcase
    endfunction

    always_comb begin
        state_n = state;
        pcnt_n  = pcnt;
        seg_n   = seg;
        ecnt_n  = ecnt;
        c       = state;
        e       = ecnt;
        adv     = 1'b0;
        if (apply || wrap) begin
            pcnt_n = '0;
            adv    = 1'b1;
            c      = S_P1;
            e      = n_tot;
        end else if (state != S_IDLE) begin
            pcnt_n = pcnt + PER_W'(1);
            if (state != S_WAIT) begin
                if (seg == (WID_W+1)'(1)) begin
                    adv = 1'b1;
                    c   = nxt_seg(state, ecnt, eff);
                    if (c == S_P2)
                        e = ecnt - NBL_W'(1);
                end else begin
                    seg_n = seg - (WID_W+1)'(1);
                end
            end
        end
        // Zero-length segments consume no cycles; at most two can chain.
        if (adv) begin
            for (int k = 0; k < 3; k++) begin
                if (c != S_WAIT && seg_len(c, eff) == '0) begin
                    c = nxt_seg(c, e, eff);
                    if (c == S_P2)
                        e = e - NBL_W'(1);
                end
            end
            state_n = c;
            seg_n   = seg_len(c, eff);
            ecnt_n  = e;
        end
    end

    assign running_n = running | apply;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            pcnt    <= '0;
            seg     <= '0;
            ecnt    <= '0;
            running <= 1'b0;
            sync_q  <= 1'b0;
            pulse_q <= 1'b0;
            inhib_q <= 1'b0;
        end else begin
            state   <= state_n;
            pcnt    <= pcnt_n;
            seg     <= seg_n;
            ecnt    <= ecnt_n;
            running <= running_n;
            sync_q  <= running_n && (pcnt_n < sync_lim);
            pulse_q <= (state_n == S_P1) || (state_n == S_P2);
            inhib_q <= eff.bl && seq_busy(state_n);
        end
    end

    assign bus.sync_on  = sync_q;
    assign bus.pulse_on = pulse_q;
    assign bus.inhib    = inhib_q;
    assign bus.running  = running;
endmodule

// File: tb/tb_cpmg_sequencer.sv
// Directed bench for cpmg_sequencer. Each step() records the outputs of one
// cycle into bit vectors indexed by cycle offset; tests compare those vectors
// against hand-built expected masks.
module tb_cpmg_sequencer;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cidx = 0;
    logic [255:0] obs_p, obs_i, obs_s, obs_a, obs_r;

    always #5 clk = ~clk;

    cpmg_sequencer_if bus ();

    cpmg_sequencer dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    function automatic logic [255:0] rng(input int lo, input int hi);
        logic [255:0] r;
        r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic clr();
        cidx  = 0;
        obs_p = '0; obs_i = '0; obs_s = '0; obs_a = '0; obs_r = '0;
    endtask

    task automatic step();
        if (cidx < 256) begin
            obs_p[cidx] = bus.pulse_on;
            obs_i[cidx] = bus.inhib;
            obs_s[cidx] = bus.sync_on;
            obs_a[cidx] = bus.upd_ack;
            obs_r[cidx] = bus.running;
        end
        cidx++;
        @(posedge clk); #1;
    endtask

    task automatic load(input int per, input int p1, input int dl, input int p2,
                        input bit cp, input int nbl, input bit bl);
        bus.per_in   = 24'(per);
        bus.p1wid_in = 16'(p1);
        bus.del_in   = 16'(dl);
        bus.p2wid_in = 16'(p2);
        bus.cp_in    = cp;
        bus.nbl_in   = 8'(nbl);
        bus.bl_in    = bl;
    endtask

    task automatic send(input int per, input int p1, input int dl, input int p2,
                        input bit cp, input int nbl, input bit bl);
        load(per, p1, dl, p2, cp, nbl, bl);
        bus.rxd = 1'b1;
        @(posedge clk); #1;
        bus.rxd = 1'b0;
    endtask

    task automatic do_reset();
        bus.rxd = 1'b0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [4:0] o;
        bus.rxd = 1'b1;
        load(100, 5, 10, 8, 0, 0, 1);
        repeat (3) @(posedge clk);
        #1;
        o = {bus.sync_on, bus.pulse_on, bus.inhib, bus.upd_ack, bus.running};
        checks++;
        if (o !== 5'b0) begin errors++; $display("FAIL reset_outputs: got %b exp 00000", o); end
        bus.rxd = 1'b0;
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        clr(); repeat (10) step();
        checks++;
        if ((obs_p | obs_i | obs_s | obs_a | obs_r) !== '0) begin
            errors++; $display("FAIL reset_idle: activity seen %h exp 0", obs_p | obs_i | obs_s | obs_a | obs_r);
        end
    endtask

    task automatic test_basic();
        logic [255:0] ex;
        do_reset();
        send(100, 5, 10, 8, 0, 0, 1);
        clr(); repeat (200) step();
        ex = rng(0, 4) | rng(15, 22) | rng(100, 104) | rng(115, 122);
        checks++; if (obs_p !== ex) begin errors++; $display("FAIL basic_pulse: got %h exp %h", obs_p, ex); end
        ex = rng(0, 32) | rng(100, 132);
        checks++; if (obs_i !== ex) begin errors++; $display("FAIL basic_inhib: got %h exp %h", obs_i, ex); end
        ex = rng(0, 7) | rng(100, 107);
        checks++; if (obs_s !== ex) begin errors++; $display("FAIL basic_sync: got %h exp %h", obs_s, ex); end
        ex = rng(0, 0);
        checks++; if (obs_a !== ex) begin errors++; $display("FAIL basic_ack: got %h exp %h", obs_a, ex); end
        ex = rng(0, 199);
        checks++; if (obs_r !== ex) begin errors++; $display("FAIL basic_running: got %h exp %h", obs_r, ex); end
    endtask

    task automatic test_cpmg();
        logic [255:0] ex;
        do_reset();
        send(200, 4, 6, 4, 1, 3, 1);
        clr(); repeat (200) step();
        ex = rng(0, 3) | rng(10, 13) | rng(26, 29) | rng(42, 45);
        checks++; if (obs_p !== ex) begin errors++; $display("FAIL cpmg_pulse: got %h exp %h", obs_p, ex); end
        ex = rng(0, 51);
        checks++; if (obs_i !== ex) begin errors++; $display("FAIL cpmg_inhib: got %h exp %h", obs_i, ex); end
        do_reset();
        send(200, 4, 6, 4, 1, 0, 1);
        clr(); repeat (200) step();
        ex = rng(0, 3) | rng(10, 13);
        checks++; if (obs_p !== ex) begin errors++; $display("FAIL cpmg_nbl0_pulse: got %h exp %h", obs_p, ex); end
        ex = rng(0, 19);
        checks++; if (obs_i !== ex) begin errors++; $display("FAIL cpmg_nbl0_inhib: got %h exp %h", obs_i, ex); end
    endtask

    task automatic test_mid_update();
        logic [255:0] ex;
        do_reset();
        send(100, 5, 10, 8, 0, 0, 1);
        clr();
        repeat (40) step();
        load(100, 20, 10, 8, 0, 0, 1);
        bus.rxd = 1'b1; step(); bus.rxd = 1'b0;
        repeat (159) step();
        ex = rng(0, 4) | rng(15, 22) | rng(100, 119) | rng(130, 137);
        checks++; if (obs_p !== ex) begin errors++; $display("FAIL mid_pulse: got %h exp %h", obs_p, ex); end
        ex = rng(0, 32) | rng(100, 147);
        checks++; if (obs_i !== ex) begin errors++; $display("FAIL mid_inhib: got %h exp %h", obs_i, ex); end
        ex = rng(0, 0) | rng(100, 100);
        checks++; if (obs_a !== ex) begin errors++; $display("FAIL mid_ack: got %h exp %h", obs_a, ex); end
        // rxd exactly on the last cycle of the period
        clr();
        repeat (99) step();
        load(100, 3, 10, 8, 0, 0, 1);
        bus.rxd = 1'b1; step(); bus.rxd = 1'b0;
        repeat (100) step();
        ex = rng(0, 19) | rng(30, 37) | rng(100, 102) | rng(113, 120);
        checks++; if (obs_p !== ex) begin errors++; $display("FAIL wrap_rxd_pulse: got %h exp %h", obs_p, ex); end
        ex = rng(100, 100);
        checks++; if (obs_a !== ex) begin errors++; $display("FAIL wrap_rxd_ack: got %h exp %h", obs_a, ex); end
    endtask

    task automatic test_overrun();
        logic [255:0] ex;
        do_reset();
        send(20, 5, 10, 10, 0, 0, 1);
        clr(); repeat (60) step();
        ex = rng(0, 4) | rng(15, 19) | rng(20, 24) | rng(35, 39) | rng(40, 44) | rng(55, 59);
        checks++; if (obs_p !== ex) begin errors++; $display("FAIL overrun_pulse: got %h exp %h", obs_p, ex); end
        ex = rng(0, 59);
        checks++; if (obs_i !== ex) begin errors++; $display("FAIL overrun_inhib: got %h exp %h", obs_i, ex); end
        ex = rng(0, 7) | rng(20, 27) | rng(40, 47);
        checks++; if (obs_s !== ex) begin errors++; $display("FAIL overrun_sync: got %h exp %h", obs_s, ex); end
        // per=1 runs as a 2-cycle period
        do_reset();
        send(1, 1, 0, 0, 0, 0, 0);
        clr(); repeat (10) step();
        ex = '0;
        for (int i = 0; i < 10; i += 2) ex[i] = 1'b1;
        checks++; if (obs_p !== ex) begin errors++; $display("FAIL per1_pulse: got %h exp %h", obs_p, ex); end
        ex = rng(0, 9);
        checks++; if (obs_s !== ex) begin errors++; $display("FAIL per1_sync: got %h exp %h", obs_s, ex); end
    endtask

    task automatic test_zero_fields();
        logic [255:0] ex;
        do_reset();
        send(50, 0, 0, 3, 0, 0, 0);
        clr(); repeat (100) step();
        ex = rng(0, 2) | rng(50, 52);
        checks++; if (obs_p !== ex) begin errors++; $display("FAIL zero_pulse: got %h exp %h", obs_p, ex); end
        checks++; if (obs_i !== '0) begin errors++; $display("FAIL zero_inhib: got %h exp 0", obs_i); end
        // two updates in one period: only the second lands
        clr();
        repeat (10) step();
        load(50, 2, 0, 0, 0, 0, 0);
        bus.rxd = 1'b1; step(); bus.rxd = 1'b0;
        repeat (9) step();
        load(50, 6, 0, 0, 0, 0, 1);
        bus.rxd = 1'b1; step(); bus.rxd = 1'b0;
        repeat (79) step();
        ex = rng(0, 2) | rng(50, 55);
        checks++; if (obs_p !== ex) begin errors++; $display("FAIL two_rxd_pulse: got %h exp %h", obs_p, ex); end
        ex = rng(50, 55);
        checks++; if (obs_i !== ex) begin errors++; $display("FAIL two_rxd_inhib: got %h exp %h", obs_i, ex); end
        ex = rng(50, 50);
        checks++; if (obs_a !== ex) begin errors++; $display("FAIL two_rxd_ack: got %h exp %h", obs_a, ex); end
    endtask

    task automatic test_async_reset();
        logic [255:0] ex;
        logic [4:0]   o;
        do_reset();
        send(100, 5, 10, 8, 0, 0, 1);
        repeat (17) @(posedge clk);
        #1;
        checks++; if (bus.pulse_on !== 1'b1) begin errors++; $display("FAIL areset_pre_p2: got %b exp 1", bus.pulse_on); end
        #2 resetn = 1'b0;
        #1;
        o = {bus.sync_on, bus.pulse_on, bus.inhib, bus.upd_ack, bus.running};
        checks++; if (o !== 5'b0) begin errors++; $display("FAIL areset_outputs: got %b exp 00000", o); end
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        clr(); repeat (30) step();
        checks++;
        if ((obs_p | obs_i | obs_s | obs_a | obs_r) !== '0) begin
            errors++; $display("FAIL areset_quiet: activity seen %h exp 0", obs_p | obs_i | obs_s | obs_a | obs_r);
        end
        send(100, 5, 10, 8, 0, 0, 1);
        clr(); repeat (10) step();
        ex = rng(0, 4);
        checks++; if (obs_p !== ex) begin errors++; $display("FAIL areset_restart: got %h exp %h", obs_p, ex); end
        ex = rng(0, 9);
        checks++; if (obs_r !== ex) begin errors++; $display("FAIL areset_running: got %h exp %h", obs_r, ex); end
    endtask

    initial begin
        bus.rxd = 1'b0;
        load(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_basic();
        test_cpmg();
        test_mid_update();
        test_overrun();
        test_zero_fields();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpmg_sequencer.md
Name: cpmg_sequencer

Overview:
- Cycle-accurate scheduler for one pulse-sequence period: generates Sync, the switch Pulse (p1, then one or a CPMG train of p2) and the receiver Block/inhibit window.
- Sits between pulse_control (parameter registers plus rx-done strobe) and the output pins; runs on the PLL clock domain.
- Owns safe parameter updates: new values are captured on a strobe and applied only at a period boundary, so a period never mixes old and new timing.

Parameters:
PER_W, 24, period counter / per_in width
WID_W, 16, width of p1wid/del/p2wid
NBL_W, 8, width of CPMG echo count
SYNC_LEN, 8, sync_on high time in cycles (clipped to period)

Ports:
clk  in  1  PLL clock
resetn  in  1  asynchronous active-low reset
per_in  in  PER_W  period length in cycles
p1wid_in  in  WID_W  first pulse width
del_in  in  WID_W  p1-end to p2-start gap (tau)
p2wid_in  in  WID_W  second/echo pulse width
cp_in  in  1  1 = CPMG train of p2 pulses
nbl_in  in  NBL_W  number of p2 pulses when cp_in=1
bl_in  in  1  1 = drive inhib window
rxd  in  1  one-cycle strobe: *_in valid, capture
sync_on  out  1  sync output
pulse_on  out  1  switch output
inhib  out  1  blocking output
upd_ack  out  1  one-cycle pulse when captured params become active
running  out  1  high once the first parameter set is active

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (resetn). All outputs are 0 on reset and the FSM is in IDLE. Shadow/active registers and the pending flag clear to 0.
- Capture: on rxd=1, all *_in are registered into the shadow set and pending is set.
- Apply: at a boundary (last cycle of period, pcnt==per_act-1, or any cycle in IDLE), if pending or rxd, shadow goes to the active set; rxd on that same cycle bypasses shadow so the inputs go directly active. Then pending clears and upd_ack=1 for 1 cycle.
- Period counter pcnt: counts 0..per_act-1 and wraps to 0. per_act<2 is treated as 2.
- Latency: rxd in IDLE at cycle N gives pcnt=0 at N+1, with running=1, sync_on=1, and pulse_on=1 if p1wid>0.
- Outputs are registered, so each one is high exactly in the pcnt cycles listed below.
- FSM states: IDLE, P1, DEL, P2, GAP, TAIL, WAIT; segment counter is WID_W+1 bits.
  - P1: pcnt in [0, p1wid).
  - DEL: del cycles.
  - P2: p2wid cycles.
  - GAP: 2*del cycles, then back to P2 while remaining echoes > 0.
  - TAIL: del cycles.
  - WAIT: until wrap, then P1.
- A zero-length segment is skipped in 0 cycles: p1wid=0 means no p1, del=0 means pulses abut, p2wid=0 means no p2 high time.
- Echo count: cp_in=0 gives one p2. cp_in=1 gives max(nbl,1) p2 pulses.
- sync_on = (pcnt < min(SYNC_LEN, per_act)).
- pulse_on = 1 in P1 and P2 only.
- inhib = bl_act & (state in P1, DEL, P2, GAP, TAIL), so it covers from pcnt=0 through the end of the last p2 plus del.
- Overrun: if the sequence has not finished at the wrap, wrap wins. All outputs deassert for nothing; the FSM restarts at P1 with pcnt=0 (truncated, never carried over).
- Update timing: an update arriving mid-period never alters the current period. Multiple rxd before a boundary: the last one wins and produces a single upd_ack.
- Reset mid-sequence: outputs drop to 0 asynchronously. The block needs a fresh rxd to restart.

Decomposition:
- Shared package pulse_pkg: state enum, default widths (PER_W/WID_W/NBL_W), SYNC_LEN, MIN_PER=2.
- Sub-module seq_param_shadow: capture/pending/apply registers plus upd_ack. It exposes the active set and an apply strobe.
- Remaining logic: FSM and counters in cpmg_sequencer.

Test Plan:
- Reset, then rxd with per=100, p1=5, del=10, p2=8, cp=0, bl=1.
  - pulse_on high pcnt 0-4 and 15-22.
  - inhib high pcnt 0-32.
  - sync_on high 0-7.
  - Pattern repeats every 100 cycles.
  - upd_ack once.
- CPMG: per=200, p1=4, del=6, p2=4, cp=1, nbl=3.
  - p2 pulses at pcnt 10-13, 26-29, 42-45.
  - inhib ends after pcnt 51.
  - With nbl=0, exactly one p2 pulse.
- Mid-period update: at pcnt=40 send rxd with p1=20.
  - Current period is unchanged.
  - New width starts at next pcnt=0.
  - upd_ack is asserted on the wrap cycle.
  - rxd exactly on the wrap cycle is applied at the following pcnt=0.
- Overrun: per=20, p1=5, del=10, p2=10.
  - pulse_on high pcnt 0-4 and 15-19 only.
  - Restarts cleanly at 0 with no stretched pulse.
  - per=1 behaves as per=2.
- Zero fields and blocking:
  - p1=0, del=0, p2=3, bl=0: pulse_on high pcnt 0-2, inhib never high.
  - Two rxd in one period: only the last values are applied, with a single upd_ack.
- Async reset: assert resetn=0 mid-P2.
  - All outputs are 0 in the same cycle and running=0.
  - No output activity until the next rxd.
